// File: rtl/fuzzificador_it2_seq_if.sv
// Handshake and configuration bundle for the interval type-2 fuzzifier.
//   master : sample producer / configuration writer / result consumer
//   slave  : the fuzzifier
// Signals:
//   in_valid/in_ready/in_data       crisp input sample, input n at [n*W +: W]
//   cfg_we/cfg_ready/cfg_addr/cfg_data
//                                   breakpoint writes, addr = (n*NSETS+s)*8 + k
//                                   (k 0..3 = A..D of UP, k 4..7 = A..D of LOW)
//   out_valid/out_ready             result bank handshake
//   FOU_UP/FOU_LOW                  upper/lower degrees, set i at [i*W +: W]
//   Ativo_UP                        bit i set when upper degree of set i is nonzero
interface fuzzificador_it2_seq_if #(
  parameter int W     = 8,
  parameter int NIN   = 2,
  parameter int NSETS = 3
);
  localparam int NSET_TOT = NIN * NSETS;
  localparam int AW       = $clog2(NSET_TOT * 8);

  logic                    in_valid;
  logic                    in_ready;
  logic [NIN*W-1:0]        in_data;
  logic                    cfg_we;
  logic                    cfg_ready;
  logic [AW-1:0]           cfg_addr;
  logic [W-1:0]            cfg_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [NSET_TOT*W-1:0]   FOU_UP;
  logic [NSET_TOT*W-1:0]   FOU_LOW;
  logic [NSET_TOT-1:0]     Ativo_UP;

  modport master (
    output in_valid, in_data, cfg_we, cfg_addr, cfg_data, out_ready,
    input  in_ready, cfg_ready, out_valid, FOU_UP, FOU_LOW, Ativo_UP
  );

  modport slave (
    input  in_valid, in_data, cfg_we, cfg_addr, cfg_data, out_ready,
    output in_ready, cfg_ready, out_valid, FOU_UP, FOU_LOW, Ativo_UP
  );
endinterface

// File: rtl/fuzzificador_it2_seq.sv
// Interval type-2 trapezoidal fuzzifier, time-multiplexed over all
// 2*NIN*NSETS trapezoids with a single restoring divider.
// Ports:
//   clk      clock
//   RESET    asynchronous active-low reset
//   EN_SCLK  clock enable; low freezes all state and handshakes
//   bus      fuzzificador_it2_seq_if.slave (input, config and result handshakes)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a sample, in_ready high, config writable
// CLASS | classify x against trapezoid t, load divider operands
// DIV   | W restoring divide steps (always run, result may be discarded)
// STORE | write degree into shadow bank, advance t
// DONE  | publish shadow bank, hold out_valid until consumer accepts
module fuzzificador_it2_seq #(
  parameter int W     = 8,
  parameter int NIN   = 2,
  parameter int NSETS = 3
) (
  input logic                   clk,
  input logic                   RESET,
  input logic                   EN_SCLK,
  fuzzificador_it2_seq_if.slave bus
);
  localparam int NSET_TOT = NIN * NSETS;
  localparam int NTRAP    = 2 * NSET_TOT;
  localparam int NBP      = NSET_TOT * 8;
  localparam int AW       = $clog2(NBP);
  localparam int TW       = $clog2(NTRAP + 1);
  localparam int CW       = $clog2(W);
  localparam logic [W-1:0]  MAX    = '1;
  localparam logic [TW-1:0] T_LAST = TW'(NTRAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASS,
    S_DIV,
    S_STORE,
    S_DONE
  } state_t;

  state_t                state;
  logic [TW-1:0]         t;
  logic [NIN*W-1:0]      x_reg;
  logic [W-1:0]          bp [NBP];
  logic [W-1:0]          shadow_up [NSET_TOT];
  logic [W-1:0]          shadow_low [NSET_TOT];
  logic                  direct;
  logic [W-1:0]          direct_val;
  logic [W-1:0]          den;
  logic [W-1:0]          rem;
  logic [W-1:0]          quo;
  logic [CW-1:0]         div_cnt;
  logic                  out_valid;
  logic [NSET_TOT*W-1:0] fou_up;
  logic [NSET_TOT*W-1:0] fou_low;
  logic [NSET_TOT-1:0]   ativo_up;
  logic                  cfg_ready;

  assign cfg_ready     = (state == S_IDLE) || (state == S_DONE);
  assign bus.cfg_ready = cfg_ready;
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid;
  assign bus.FOU_UP    = fou_up;
  assign bus.FOU_LOW   = fou_low;
  assign bus.Ativo_UP  = ativo_up;

  // Breakpoint fetch for trapezoid t: set i = t>>1, t[0] selects the LOW quad.
  logic [TW-1:0]   set_i;
  logic [AW-4:0]   blk;
  logic [W-1:0]    a_v, b_v, c_v, d_v;
  logic [W-1:0]    x_cur;
  int              n_i;

  assign set_i = t >> 1;
  assign blk   = (AW-3)'(set_i);
  assign a_v   = bp[{blk, t[0], 2'd0}];
  assign b_v   = bp[{blk, t[0], 2'd1}];
  assign c_v   = bp[{blk, t[0], 2'd2}];
  assign d_v   = bp[{blk, t[0], 2'd3}];

  always_comb begin
    n_i   = int'(set_i) / NSETS;
    x_cur = x_reg[n_i*W +: W];
  end

  // Classification in priority order; only the slope cases use the divider.
  logic           cls_direct;
  logic [W-1:0]   cls_val;
  logic [W-1:0]   cls_den;
  logic [2*W-1:0] cls_num;

  always_comb begin
    cls_direct = 1'b1;
    cls_val    = '0;
    cls_den    = '0;
    cls_num    = '0;
    if (x_cur < a_v) begin
      cls_val = '0;
    end else if (x_cur > d_v) begin
      cls_val = '0;
    end else if (x_cur >= b_v && x_cur <= c_v) begin
      cls_val = MAX;
    end else if (x_cur < b_v) begin
      cls_direct = 1'b0;
      cls_num    = {W'(0), x_cur - a_v} * {W'(0), MAX};
      cls_den    = b_v - a_v;
    end else begin
      cls_direct = 1'b0;
      cls_num    = {W'(0), d_v - x_cur} * {W'(0), MAX};
      cls_den    = d_v - c_v;
    end
  end

  // One restoring step: dividend bits shift out of quo's MSB into rem while
  // quotient bits shift in at quo's LSB. den=0 always subtracts, giving MAX.
  logic [W:0]   trial;
  logic [W-1:0] rem_nxt;
  logic [W-1:0] quo_nxt;

  always_comb begin
    trial = {rem, quo[W-1]};
    if (trial >= {1'b0, den}) begin
      rem_nxt = W'(trial - {1'b0, den});
      quo_nxt = {quo[W-2:0], 1'b1};
    end else begin
      rem_nxt = trial[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state      <= S_IDLE;
      t          <= '0;
      x_reg      <= '0;
      direct     <= 1'b0;
      direct_val <= '0;
      den        <= '0;
      rem        <= '0;
      quo        <= '0;
      div_cnt    <= '0;
      out_valid  <= 1'b0;
      fou_up     <= '0;
      fou_low    <= '0;
      ativo_up   <= '0;
      for (int k = 0; k < NBP; k++) bp[k] <= '0;
      for (int k = 0; k < NSET_TOT; k++) begin
        shadow_up[k]  <= '0;
        shadow_low[k] <= '0;
      end
    end else if (EN_SCLK) begin
      if (bus.cfg_we && cfg_ready && (int'(bus.cfg_addr) < NBP))
        bp[bus.cfg_addr] <= bus.cfg_data;

      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            x_reg <= bus.in_data;
            t     <= '0;
            state <= S_CLASS;
          end
        end
        S_CLASS: begin
          direct     <= cls_direct;
          direct_val <= cls_val;
          den        <= cls_den;
          rem        <= cls_num[2*W-1:W];
          quo        <= cls_num[W-1:0];
          div_cnt    <= CW'(W - 1);
          state      <= S_DIV;
        end
        S_DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (div_cnt == '0) state <= S_STORE;
          else               div_cnt <= div_cnt - 1'b1;
        end
        S_STORE: begin
          if (t[0]) shadow_low[set_i] <= direct ? direct_val : quo;
          else      shadow_up[set_i]  <= direct ? direct_val : quo;
          t <= t + 1'b1;
          if (t == T_LAST) state <= S_DONE;
          else             state <= S_CLASS;
        end
        S_DONE: begin
          // First DONE cycle publishes the bank; afterwards wait for acceptance.
          if (!out_valid) begin
            for (int k = 0; k < NSET_TOT; k++) begin
              fou_up[k*W +: W]  <= shadow_up[k];
              fou_low[k*W +: W] <= shadow_low[k];
              ativo_up[k]       <= (shadow_up[k] != '0);
            end
            out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fuzzificador_it2_seq.sv
// Scoreboard bench for fuzzificador_it2_seq: the stimulus side pushes the
// reference-model result for every accepted sample; a monitor pops and
// compares each time a new result bank appears.
module tb_fuzzificador_it2_seq;
  localparam int W     = 8;
  localparam int NIN   = 2;
  localparam int NSETS = 3;
  localparam int NS    = NIN * NSETS;
  localparam int NBP   = NS * 8;
  localparam int AW    = $clog2(NBP);
  localparam int MAXV  = (1 << W) - 1;
  localparam int LAT   = 2 * NS * (W + 2) + 1;

  typedef struct {
    logic [NS*W-1:0] up;
    logic [NS*W-1:0] low;
    logic [NS-1:0]   act;
    int              hs;
    int              lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_sclk = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   bp_m [NBP];
  exp_t exp_q [$];
  exp_t last_exp;
  logic prev_ov = 1'b0;

  fuzzificador_it2_seq_if #(.W(W), .NIN(NIN), .NSETS(NSETS)) bus ();

  fuzzificador_it2_seq #(.W(W), .NIN(NIN), .NSETS(NSETS)) dut (
    .clk     (clk),
    .RESET   (rst),
    .EN_SCLK (en_sclk),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  function automatic int memb(input int x, input int a, input int b, input int c, input int d);
    if (x < a) return 0;
    if (x > d) return 0;
    if (b <= x && x <= c) return MAXV;
    if (x < b) return ((x - a) * MAXV) / (b - a);
    if (d == c) return MAXV;
    return ((d - x) * MAXV) / (d - c);
  endfunction

  function automatic exp_t model(input logic [NIN*W-1:0] d);
    exp_t e;
    e.up = '0; e.low = '0; e.act = '0; e.hs = 0; e.lat = 0;
    for (int i = 0; i < NS; i++) begin
      int x, u, l;
      x = int'(d[(i / NSETS) * W +: W]);
      u = memb(x, bp_m[i*8], bp_m[i*8+1], bp_m[i*8+2], bp_m[i*8+3]);
      l = memb(x, bp_m[i*8+4], bp_m[i*8+5], bp_m[i*8+6], bp_m[i*8+7]);
      e.up[i*W +: W]  = W'(u);
      e.low[i*W +: W] = W'(l);
      e.act[i]        = (u != 0);
    end
    return e;
  endfunction

  function automatic logic [NIN*W-1:0] pack(input int x0, input int x1);
    return {W'(x1), W'(x0)};
  endfunction

  // Monitor: a rising out_valid marks a fresh result bank.
  always @(negedge clk) begin
    if (rst && bus.out_valid && !prev_ov) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("fou_up", 64'(bus.FOU_UP), 64'(e.up));
        chk("fou_low", 64'(bus.FOU_LOW), 64'(e.low));
        chk("ativo_up", 64'(bus.Ativo_UP), 64'(e.act));
        if (e.lat > 0) chk("latency", 64'(cyc - e.hs), 64'(e.lat));
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic cfg_write(input int addr, input int data);
    int k;
    k = 0;
    @(negedge clk);
    bus.cfg_addr = AW'(addr);
    bus.cfg_data = W'(data);
    bus.cfg_we   = 1'b1;
    while (!(bus.cfg_ready && en_sclk) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) chk("cfg_write_timeout", 64'd1, 64'd0);
    else bp_m[addr] = data;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic send(input logic [NIN*W-1:0] d, input int lat);
    exp_t e;
    int k;
    k = 0;
    e = model(d);
    e.lat = lat;
    @(negedge clk);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!(bus.in_ready && en_sclk) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      chk("send_timeout", 64'd1, 64'd0);
    end else begin
      e.hs = cyc + 1;
      exp_q.push_back(e);
      last_exp = e;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && bus.in_ready && !bus.out_valid) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      chk("wait_idle_timeout", 64'd1, 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic run(input int x0, input int x1);
    send(pack(x0, x1), LAT);
    wait_idle();
  endtask

  initial begin
    int v [4];
    int tmp;
    exp_t eb;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NBP; i++) bp_m[i] = 0;
    last_exp = model('0);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_fou_up", 64'(bus.FOU_UP), 64'd0);
    chk("rst_fou_low", 64'(bus.FOU_LOW), 64'd0);
    chk("rst_ativo", 64'(bus.Ativo_UP), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Reference configuration and nominal sample
    cfg_write(0, 0);    cfg_write(1, 1);   cfg_write(2, 51);   cfg_write(3, 114);
    cfg_write(4, 0);    cfg_write(5, 1);   cfg_write(6, 51);   cfg_write(7, 107);
    cfg_write(8, 5);    cfg_write(9, 77);  cfg_write(10, 153); cfg_write(11, 222);
    cfg_write(16, 118); cfg_write(17, 179); cfg_write(18, 254); cfg_write(19, 255);
    run(80, 0);
    run(80, 200);

    // Breakpoint boundaries of set0 UP
    run(0, 7);
    run(1, 7);
    run(51, 7);
    run(114, 7);
    run(113, 7);

    // Backpressure: result held, new sample waits
    bus.out_ready = 1'b0;
    send(pack(60, 33), LAT);
    begin
      int k;
      k = 0;
      while (!bus.out_valid && k < 300) begin
        @(negedge clk);
        k++;
      end
      if (k >= 300) chk("bp_wait_timeout", 64'd1, 64'd0);
    end
    bus.in_data  = pack(150, 90);
    bus.in_valid = 1'b1;
    repeat (50) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_fou_up", 64'(bus.FOU_UP), 64'(last_exp.up));
      chk("bp_fou_low", 64'(bus.FOU_LOW), 64'(last_exp.low));
      chk("bp_ativo", 64'(bus.Ativo_UP), 64'(last_exp.act));
    end
    eb = model(pack(150, 90));
    eb.hs  = cyc + 2;
    eb.lat = LAT;
    exp_q.push_back(eb);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", 64'(bus.in_ready), 64'd1);
    chk("bp_release_ov", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("bp_recapture", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    wait_idle();

    // Config write dropped while evaluating, accepted in IDLE
    send(pack(30, 0), LAT);
    repeat (20) @(negedge clk);
    bus.cfg_addr = AW'(1);
    bus.cfg_data = W'(40);
    bus.cfg_we   = 1'b1;
    chk("cfg_ready_busy", 64'(bus.cfg_ready), 64'd0);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    wait_idle();
    run(30, 0);
    cfg_write(1, 40);
    run(30, 0);

    // Misordered breakpoints
    cfg_write(8, 10);  cfg_write(9, 10);  cfg_write(10, 10); cfg_write(11, 10);
    cfg_write(12, 20); cfg_write(13, 20); cfg_write(14, 5);  cfg_write(15, 30);
    run(10, 0);
    run(25, 0);

    // Asynchronous reset in the middle of an evaluation
    send(pack(80, 40), LAT);
    repeat (58) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    chk("mid_rst_fou_up", 64'(bus.FOU_UP), 64'd0);
    chk("mid_rst_fou_low", 64'(bus.FOU_LOW), 64'd0);
    chk("mid_rst_ativo", 64'(bus.Ativo_UP), 64'd0);
    exp_q.delete();
    for (int i = 0; i < NBP; i++) bp_m[i] = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    run(80, 0);

    // Clock-enable gap stretches latency
    cfg_write(0, 0); cfg_write(1, 1); cfg_write(2, 51); cfg_write(3, 114);
    send(pack(90, 3), LAT + 10);
    repeat (5) @(negedge clk);
    en_sclk = 1'b0;
    repeat (10) @(negedge clk);
    en_sclk = 1'b1;
    wait_idle();

    // Randomized breakpoints and inputs
    for (int r = 0; r < 4; r++) begin
      for (int q = 0; q < NS * 2; q++) begin
        for (int j = 0; j < 4; j++) v[j] = int'($urandom_range(0, MAXV));
        for (int p = 0; p < 3; p++)
          for (int j = 0; j < 3 - p; j++)
            if (v[j] > v[j+1]) begin
              tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp;
            end
        for (int j = 0; j < 4; j++) cfg_write(q * 4 + j, v[j]);
      end
      for (int s = 0; s < 3; s++)
        run(int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)));
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) chk("leftover_expect", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
